hcsr04_meas_sched: RTL and testbench

Measurement scheduler in front of the hc_sr04 ranging core. It merges single-shot button requests with periodic continuous requests into one measure pulse stream. It enforces a minimum inter-ping gap, supervises the ready handshake with a timeout, and captures each result. It also derives a hysteretic "near" flag for the lamp/servo logic.

---
 rtl/hcsr04_meas_sched_pkg.sv | 16 +
 rtl/hcsr04_meas_sched_if.sv | 13 +
 rtl/hcsr04_meas_sched_down_counter.sv | 24 ++
 rtl/hcsr04_meas_sched.sv | 114 +++++++++++
 tb/tb_hcsr04_meas_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hcsr04_meas_sched_pkg.sv
// hcsr04_sched_pkg: scheduler state encoding, default sizing and counter-width helper
package hcsr04_sched_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, CAPTURE, GAP} state_t;

    localparam int DIST_W_D      = 22;
    localparam int GAP_CYC_D     = 6_000_000;
    localparam int PERIOD_CYC_D  = 25_000_000;
    localparam int TIMEOUT_CYC_D = 4_000_000;

    // bits needed to hold n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hcsr04_meas_sched_if.sv
// hcsr04_meas_sched_if: measure/ready/distance handshake between scheduler and hc_sr04 core
interface hcsr04_meas_sched_if
    import hcsr04_sched_pkg::*;
#(
    parameter int DIST_W = DIST_W_D
);
    logic              measure;
    logic              ready;
    logic [DIST_W-1:0] distance;

    modport master (output measure, input ready, input distance);
    modport slave  (input measure, output ready, output distance);
endinterface

// File: rtl/hcsr04_meas_sched_down_counter.sv
// sched_down_counter: loadable down-counter that flags expiry while enabled at zero
module sched_down_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    assign expired = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
endmodule

// File: rtl/hcsr04_meas_sched.sv
// hcsr04_meas_sched: merges single/periodic requests into gapped, timeout-guarded hc_sr04 pings
// Define HCSR04_AVG4_EN to report the mean of the last four samples instead of the raw sample.
module hcsr04_meas_sched
    import hcsr04_sched_pkg::*;
#(
    parameter int                DIST_W      = DIST_W_D,
    parameter int                GAP_CYC     = GAP_CYC_D,
    parameter int                PERIOD_CYC  = PERIOD_CYC_D,
    parameter int                TIMEOUT_CYC = TIMEOUT_CYC_D,
    parameter logic [DIST_W-1:0] NEAR_TH     = DIST_W'('h010000),
    parameter logic [DIST_W-1:0] HYST        = DIST_W'('h001000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_single,
    input  logic                cont_en,
    hcsr04_meas_sched_if.master core,
    output logic                busy,
    output logic [DIST_W-1:0]   dist_q,
    output logic                dist_valid,
    output logic                near,
    output logic                timeout_err,
    output logic [7:0]          meas_cnt
);
    localparam int PW = cnt_w(PERIOD_CYC);
    localparam int GW = cnt_w(GAP_CYC);
    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam logic [DIST_W:0] REL_TH = {1'b0, NEAR_TH} + {1'b0, HYST};

    state_t            state, nxt;
    logic              pending, per_exp, gap_exp, tmo_exp, cap, tmo;
    logic [DIST_W-1:0] samp;

    sched_down_counter #(.W(PW), .RST_VAL(PW'(PERIOD_CYC - 1))) u_period (
        .clk(clk), .rst(rst), .load(!cont_en || per_exp), .load_val(PW'(PERIOD_CYC - 1)),
        .en(cont_en), .expired(per_exp)
    );

    sched_down_counter #(.W(GW)) u_gap (
        .clk(clk), .rst(rst), .load(state == CAPTURE || tmo), .load_val(GW'(GAP_CYC - 1)),
        .en(state == GAP), .expired(gap_exp)
    );

    sched_down_counter #(.W(TW)) u_timeout (
        .clk(clk), .rst(rst), .load(state == START), .load_val(TW'(TIMEOUT_CYC - 1)),
        .en(state == WAIT_LOW || state == WAIT_HIGH), .expired(tmo_exp)
    );

    // a ready edge arriving on the expiry cycle still counts as progress
    assign cap          = (state == WAIT_HIGH) && core.ready;
    assign tmo          = tmo_exp && ((state == WAIT_LOW) ? core.ready : !core.ready);
    assign core.measure = (state == START);

`ifdef HCSR04_AVG4_EN
    logic [DIST_W-1:0] h0, h1, h2;
    logic              primed;
    logic [DIST_W+1:0] sum;

    // first sample after reset stands in for the whole history
    assign sum  = primed ? (DIST_W+2)'(core.distance) + (DIST_W+2)'(h0) + (DIST_W+2)'(h1) + (DIST_W+2)'(h2)
                         : {core.distance, 2'b00};
    assign samp = sum[DIST_W+1:2];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            primed <= 1'b0;
            h0     <= '0;
            h1     <= '0;
            h2     <= '0;
        end else if (cap) begin
            primed <= 1'b1;
            h0     <= core.distance;
            h1     <= primed ? h0 : core.distance;
            h2     <= primed ? h1 : core.distance;
        end
`else
    assign samp = core.distance;
`endif

    always_comb begin
        nxt        = state;
        busy       = state inside {START, WAIT_LOW, WAIT_HIGH, CAPTURE};
        dist_valid = (state == CAPTURE);
        case (state)
            IDLE:      nxt = (pending && core.ready) ? START : IDLE;
            START:     nxt = WAIT_LOW;
            WAIT_LOW:  nxt = !core.ready ? WAIT_HIGH : tmo ? GAP : WAIT_LOW;
            WAIT_HIGH: nxt = cap ? CAPTURE : tmo ? GAP : WAIT_HIGH;
            CAPTURE:   nxt = GAP;
            GAP:       nxt = gap_exp ? IDLE : GAP;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            dist_q      <= '0;
            near        <= 1'b0;
            timeout_err <= 1'b0;
            meas_cnt    <= '0;
        end else begin
            state   <= nxt;
            pending <= (nxt == START) ? 1'b0 : (pending || req_single || per_exp);
            if (cap) begin
                dist_q      <= samp;
                near        <= (samp < NEAR_TH) ? 1'b1 : ({1'b0, samp} >= REL_TH) ? 1'b0 : near;
                meas_cnt    <= meas_cnt + 8'd1;
                timeout_err <= 1'b0;
            end else if (tmo)
                timeout_err <= 1'b1;
        end
endmodule

// File: tb/tb_hcsr04_meas_sched.sv
// tb_hcsr04_meas_sched: randomized bench with a transaction-level scheduler/sensor model
module tb_hcsr04_meas_sched;
    localparam int DW   = 22;
    localparam int GAP  = 20;
    localparam int PER  = 100;
    localparam int TMO  = 50;
    localparam int NEAR = 'h010000;
    localparam int HYS  = 'h001000;

    logic          clk = 0, rst = 0, req_single = 0, cont_en = 0;
    logic          busy, dist_valid, near, timeout_err;
    logic [DW-1:0] dist_q;
    logic [7:0]    meas_cnt;

    hcsr04_meas_sched_if #(.DIST_W(DW)) core ();

    hcsr04_meas_sched #(.DIST_W(DW), .GAP_CYC(GAP), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_single(req_single), .cont_en(cont_en), .core(core),
        .busy(busy), .dist_q(dist_q), .dist_valid(dist_valid), .near(near),
        .timeout_err(timeout_err), .meas_cnt(meas_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_dist();
        return ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range('h00E000, 'h012000));
    endfunction

    // sensor model: answers each measure pulse with a low phase then a high phase carrying the distance
    bit            dead = 0, rnd = 0;
    int            lo_dly = 3, hi_dly = 10, rise_cyc = 0;
    logic [DW-1:0] next_d = '0;
    logic [DW-1:0] exp_q[$];

    initial begin
        core.ready    = 1'b1;
        core.distance = '0;
        forever begin
            @(negedge clk);
            if (core.measure === 1'b1 && !dead) begin
                int lo, hi;
                logic [DW-1:0] d;
                lo = rnd ? $urandom_range(1, 4) : lo_dly;
                hi = rnd ? lo + $urandom_range(1, 12) : hi_dly;
                d  = rnd ? rnd_dist() : next_d;
                repeat (lo) @(negedge clk);
                core.ready = 1'b0;
                repeat (hi - lo) @(negedge clk);
                core.distance = d;
                core.ready    = 1'b1;
                rise_cyc      = cyc;
                if (rst) exp_q.push_back(d);
            end
        end
    end

    // reference model and event monitor
    int            meas_count = 0, dv_count = 0, to_count = 0, last_meas = 0, last_dv = 0, end_min = 0;
    int            meas_q[$];
    int            m_cnt = 0, m_n = 0;
    int            m_hist[4];
    logic          m_near = 0;
    logic [DW-1:0] m_dq = '0;
    bit            prev_meas = 0, prev_te = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_cnt = 0; m_n = 0; m_near = 0; m_dq = '0; end_min = 0; prev_meas = 0; prev_te = 0;
        end else begin
            if (core.measure) begin
                check("meas_width", prev_meas, 0);
                check("meas_gap", cyc >= end_min, 1);
                meas_count++;
                last_meas = cyc;
                meas_q.push_back(cyc);
            end
            if (dist_valid) begin
                int v;
                if (exp_q.size() == 0)
                    check("dv_src", 0, 1);
                else begin
                    v = int'(exp_q.pop_front());
`ifdef HCSR04_AVG4_EN
                    if (m_n == 0) for (int i = 0; i < 4; i++) m_hist[i] = v;
                    else begin
                        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                        m_hist[0] = v;
                    end
                    v = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`endif
                    m_n++;
                    m_dq   = DW'(v);
                    m_near = (v < NEAR) ? 1'b1 : (v >= NEAR + HYS) ? 1'b0 : m_near;
                    m_cnt  = (m_cnt + 1) % 256;
                    check("dv_lat", cyc, rise_cyc + 1);
                    check("dv_dq", dist_q, m_dq);
                    check("dv_near", near, m_near);
                    check("dv_cnt", meas_cnt, m_cnt);
                    check("dv_terr", timeout_err, 0);
                    check("dv_busy", busy, 1);
                end
                dv_count++;
                last_dv = cyc;
                end_min = cyc + GAP + 2;
            end
            if (timeout_err && !prev_te) begin
                check("to_lat", cyc, last_meas + TMO + 1);
                to_count++;
                end_min = cyc + GAP + 1;
            end
            prev_meas = core.measure;
            prev_te   = timeout_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(output int rc);
        @(negedge clk);
        req_single = 1'b1;
        rc = cyc;
        @(negedge clk);
        req_single = 1'b0;
    endtask

    task automatic wait_meas(input int target, input string tag);
        int n = 0;
        while (meas_count < target && n < 300) begin @(negedge clk); n++; end
        check(tag, meas_count >= target, 1);
    endtask

    task automatic wait_dv(input int target, input string tag);
        int n = 0;
        while (dv_count < target && n < 300) begin @(negedge clk); n++; end
        check(tag, dv_count >= target, 1);
    endtask

    // one request from a settled idle scheduler: measure must follow two cycles after the request
    task automatic measure_once(input logic [DW-1:0] d);
        int m0, v0, rc;
        m0 = meas_count; v0 = dv_count;
        rnd = 0; next_d = d;
        pulse_req(rc);
        wait_dv(v0 + 1, "once_dv");
        check("once_n", meas_count - m0, 1);
        if (meas_count > m0) check("once_lat", meas_q[m0], rc + 2);
        tick(GAP + 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, v0, t0, rc, e, n;
        tick(3);
        check("rst_flags", {core.measure, busy, dist_valid, near, timeout_err}, 0);
        check("rst_cnt", meas_cnt, 0);
        check("rst_dq", dist_q, 0);
        rst = 1;
        tick(5);

        lo_dly = 3; hi_dly = 10;
        measure_once(DW'('h000800));
        check("s1_dq", dist_q, 'h000800);
        check("s1_near", near, 1);
        check("s1_cnt", meas_cnt, 1);

        measure_once(DW'('h00F000));
`ifndef HCSR04_AVG4_EN
        check("hys_a", near, 1);
`endif
        measure_once(DW'('h010800));
`ifndef HCSR04_AVG4_EN
        check("hys_b", near, 1);
`endif
        measure_once(DW'('h011000));
`ifndef HCSR04_AVG4_EN
        check("hys_c", near, 0);
`endif
        check("hys_model", near, m_near);

        // requests during busy collapse into one follow-up after the gap
        m0 = meas_count; v0 = dv_count; rnd = 0; next_d = DW'('h000900);
        pulse_req(rc);
        wait_meas(m0 + 1, "col_first");
        pulse_req(rc); tick(1); pulse_req(rc); tick(1); pulse_req(rc);
        check("col_busy", busy, 1);
        wait_dv(v0 + 1, "col_dv1");
        wait_meas(m0 + 2, "col_follow");
        if (meas_count > m0 + 1) check("col_at", meas_q[m0 + 1], last_dv + GAP + 2);
        wait_dv(v0 + 2, "col_dv2");
        tick(200);
        check("col_n", meas_count - m0, 2);

        // timeout: sensor never answers
        dead = 1; v0 = dv_count; t0 = to_count;
        pulse_req(rc);
        n = 0;
        while (to_count == t0 && n < 200) begin @(negedge clk); n++; end
        check("to_seen", to_count, t0 + 1);
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_nodv", dv_count, v0);
        check("to_dq", dist_q, m_dq);
        dead = 0;
        tick(GAP + 3);
        measure_once(rnd_dist());
        check("to_clear", timeout_err, 0);

        // continuous mode with randomized sensor timing
        m0 = meas_count; rnd = 1;
        @(negedge clk);
        cont_en = 1'b1;
        e = cyc;
        tick(990);
        cont_en = 1'b0;
        tick(150);
        n = meas_count - m0;
        check("cont_n", n, 990 / PER);
        if (n > 0) check("cont_first", meas_q[m0], e + PER + 1);
        for (int i = 1; i < n; i++) check("cont_step", meas_q[m0 + i] - meas_q[m0 + i - 1], PER);

        // randomized single shots, enough to wrap meas_cnt
        for (int i = 0; i < 250; i++) begin
            lo_dly = $urandom_range(1, 4);
            hi_dly = lo_dly + $urandom_range(1, 12);
            measure_once(rnd_dist());
            tick($urandom_range(0, 5));
        end

        // asynchronous reset in WAIT_HIGH
        lo_dly = 3; hi_dly = 10;
        measure_once(DW'('h000800));
        lo_dly = 3; hi_dly = 15; rnd = 0;
        m0 = meas_count;
        pulse_req(rc);
        wait_meas(m0 + 1, "ar_meas");
        tick(6);
        check("ar_pre_busy", busy, 1);
        #2 rst = 0;
        #1;
        check("ar_flags", {core.measure, busy, dist_valid, near, timeout_err}, 0);
        check("ar_cnt", meas_cnt, 0);
        check("ar_dq", dist_q, 0);
        tick(20);
        rst = 1;
        m0 = meas_count;
        tick(200);
        check("ar_nomeas", meas_count, m0);
        lo_dly = 3; hi_dly = 10;
        measure_once(DW'('h012345));
        check("ar_cnt_after", meas_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
